// File: rtl/can_pkg.sv
// Shared CAN receive-path types and constants for the bit destuffer.
package can_pkg;

  localparam int unsigned CAN_STUFF_LEN = 5;
  localparam int unsigned CAN_SIZE_W    = 10;
  localparam logic        CAN_DOMINANT  = 1'b0;
  localparam logic        CAN_RECESSIVE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPECT_STUFF,
    ERROR
  } destuff_state_t;

  // Run-tracker update selected by the destuffer FSM for the current cycle.
  typedef enum logic [1:0] {
    RUN_HOLD,
    RUN_COUNT,
    RUN_RESTART,
    RUN_UNTRACKED
  } run_op_t;

endpackage

// File: rtl/can_run_tracker.sv
// Tracks the level and length of the current run of identical bus bits.
module can_run_tracker
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    clear,
  input  run_op_t op,
  input  logic    rx_bit,
  output logic    same_bit,
  output logic    run_full
);

  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);

  logic             last_bit;
  logic             base_last;
  logic             nxt_last;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] base_len;
  logic [RUN_W-1:0] cnt_len;
  logic [RUN_W-1:0] nxt_len;

  // clear acts combinationally so a bit sampled with frame_start sees a fresh run
  always_comb begin
    base_last = clear ? CAN_RECESSIVE : last_bit;
    base_len  = clear ? '0 : run_len;
    same_bit  = (rx_bit == base_last);
    if (!same_bit)
      cnt_len = RUN_W'(1);
    else if (base_len == RUN_W'(STUFF_LEN))
      cnt_len = base_len;
    else
      cnt_len = base_len + 1'b1;
    run_full = (cnt_len == RUN_W'(STUFF_LEN));

    nxt_last = base_last;
    nxt_len  = base_len;
    case (op)
      RUN_COUNT: begin
        nxt_last = rx_bit;
        nxt_len  = cnt_len;
      end
      RUN_RESTART: begin
        nxt_last = rx_bit;
        nxt_len  = RUN_W'(1);
      end
      RUN_UNTRACKED: begin
        nxt_last = CAN_RECESSIVE;
        nxt_len  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_bit <= CAN_RECESSIVE;
      run_len  <= '0;
    end else begin
      last_bit <= nxt_last;
      run_len  <= nxt_len;
    end
  end

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN receive bit destuffer with stuff-error detection and frame bit count.
// Optional stuff-bit counter output when CAN_DESTUFF_STATS_EN is defined.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN,
  parameter int unsigned SIZE_W    = CAN_SIZE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sp,
  input  logic              rx_bit,
  input  logic              stuff_en,
  input  logic              frame_start,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              is_stuff,
  output logic              stuff_err,
  output logic              err,
`ifdef CAN_DESTUFF_STATS_EN
  output logic [7:0]        stuff_cnt,
`endif
  output logic [SIZE_W-1:0] size
);

  destuff_state_t    state;
  destuff_state_t    eff_state;
  destuff_state_t    state_n;
  run_op_t           run_op;
  logic              same_bit;
  logic              run_full;
  logic              valid_n;
  logic              out_n;
  logic              stuff_n;
  logic              serr_n;
  logic [SIZE_W-1:0] size_base;
  logic [SIZE_W-1:0] size_n;
`ifdef CAN_DESTUFF_STATS_EN
  logic [7:0]        cnt_base;
  logic [7:0]        cnt_n;
`endif

  can_run_tracker #(
    .STUFF_LEN (STUFF_LEN)
  ) u_run (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (frame_start),
    .op       (run_op),
    .rx_bit   (rx_bit),
    .same_bit (same_bit),
    .run_full (run_full)
  );

  // frame_start overrides the registered state so a coincident sp is handled as COUNT
  always_comb begin
    eff_state = frame_start ? COUNT : state;
    size_base = frame_start ? '0 : size;
    state_n   = eff_state;
    run_op    = RUN_HOLD;
    valid_n   = 1'b0;
    out_n     = bit_out;
    stuff_n   = 1'b0;
    serr_n    = 1'b0;
    size_n    = size_base;
`ifdef CAN_DESTUFF_STATS_EN
    cnt_base  = frame_start ? '0 : stuff_cnt;
    cnt_n     = cnt_base;
`endif
    case (eff_state)
      COUNT: begin
        if (sp) begin
          valid_n = 1'b1;
          out_n   = rx_bit;
          size_n  = (size_base == '1) ? size_base : size_base + 1'b1;
          if (stuff_en) begin
            run_op = RUN_COUNT;
            if (run_full)
              state_n = EXPECT_STUFF;
          end else begin
            run_op = RUN_UNTRACKED;
          end
        end
      end
      EXPECT_STUFF: begin
        if (sp) begin
          if (!same_bit) begin
            stuff_n = 1'b1;
            run_op  = RUN_RESTART;
            state_n = COUNT;
`ifdef CAN_DESTUFF_STATS_EN
            cnt_n   = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
`endif
          end else begin
            serr_n  = 1'b1;
            state_n = ERROR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_valid <= 1'b0;
      bit_out   <= CAN_RECESSIVE;
      is_stuff  <= 1'b0;
      stuff_err <= 1'b0;
      err       <= 1'b0;
      size      <= '0;
`ifdef CAN_DESTUFF_STATS_EN
      stuff_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      bit_valid <= valid_n;
      bit_out   <= out_n;
      is_stuff  <= stuff_n;
      stuff_err <= serr_n;
      err       <= (state_n == ERROR);
      size      <= size_n;
`ifdef CAN_DESTUFF_STATS_EN
      stuff_cnt <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed self-checking bench for can_bit_destuffer.
module tb_can_bit_destuffer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sp;
  logic       rx_bit;
  logic       stuff_en;
  logic       frame_start;
  logic       bit_valid;
  logic       bit_out;
  logic       is_stuff;
  logic       stuff_err;
  logic       err;
  logic [9:0] size;
`ifdef CAN_DESTUFF_STATS_EN
  logic [7:0] stuff_cnt;
`endif

  int checks = 0;
  int errors = 0;

  can_bit_destuffer #(
    .STUFF_LEN (5),
    .SIZE_W    (10)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sp          (sp),
    .rx_bit      (rx_bit),
    .stuff_en    (stuff_en),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_out     (bit_out),
    .is_stuff    (is_stuff),
    .stuff_err   (stuff_err),
    .err         (err),
`ifdef CAN_DESTUFF_STATS_EN
    .stuff_cnt   (stuff_cnt),
`endif
    .size        (size)
  );

  always #5 clk = ~clk;

  // Flags packed as {bit_valid, bit_out, is_stuff, stuff_err, err}.
  logic [4:0] obs;
  assign obs = {bit_valid, bit_out, is_stuff, stuff_err, err};

  // Called at a negedge; drives one sp cycle and returns at the negedge
  // where the registered response is visible.
  task automatic send(input logic b, input logic se, input logic fs);
    sp          = 1'b1;
    rx_bit      = b;
    stuff_en    = se;
    frame_start = fs;
    @(negedge clk);
    sp          = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", obs, 5'b01000);
    end
    checks++;
    if (size !== 10'd0) begin
      errors++;
      $display("FAIL reset_size: got %0d expected 0", size);
    end
    reset_n = 1'b1;
    @(negedge clk);
    send(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 5'b01000 || size !== 10'd0) begin
      errors++;
      $display("FAIL idle_sp: got %b/%0d expected 01000/0", obs, size);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] bits;
    logic [4:0] exp;
    bits = 4'b1010;
    fstart();
    for (int i = 0; i < 4; i++) begin
      send(bits[i], 1'b1, 1'b0);
      exp = {1'b1, bits[i], 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL alternate step %0d: got %b expected %b", i, obs, exp);
      end
    end
    checks++;
    if (size !== 10'd4) begin
      errors++;
      $display("FAIL alternate_size: got %0d expected 4", size);
    end
  endtask

  task automatic test_stuff();
    logic [6:0] bits;
    logic [4:0] exp;
    bits = 7'b1100000;
    fstart();
    for (int i = 0; i < 7; i++) begin
      send(bits[i], 1'b1, 1'b0);
      if (i == 5) exp = 5'b00100;
      else        exp = {1'b1, bits[i], 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stuff step %0d: got %b expected %b", i, obs, exp);
      end
    end
    checks++;
    if (size !== 10'd6) begin
      errors++;
      $display("FAIL stuff_size: got %0d expected 6", size);
    end
  endtask

  task automatic test_chain();
    logic [10:0] bits;
    logic [4:0]  exp;
    bits = 11'b01111100000;
    fstart();
    for (int i = 0; i < 11; i++) begin
      send(bits[i], 1'b1, 1'b0);
      if (i == 5)       exp = 5'b00100;
      else if (i == 10) exp = 5'b01100;
      else              exp = {1'b1, bits[i], 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL chain step %0d: got %b expected %b", i, obs, exp);
      end
    end
    checks++;
    if (size !== 10'd9) begin
      errors++;
      $display("FAIL chain_size: got %0d expected 9", size);
    end
`ifdef CAN_DESTUFF_STATS_EN
    checks++;
    if (stuff_cnt !== 8'd2) begin
      errors++;
      $display("FAIL chain_stuff_cnt: got %0d expected 2", stuff_cnt);
    end
`endif
  endtask

  task automatic test_stuff_en_drop();
    logic [4:0] exp;
    fstart();
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== 5'b00100) begin
      errors++;
      $display("FAIL pending_stuff: got %b expected 00100", obs);
    end
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b0, 1'b0);
      exp = 5'b11000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL untracked step %0d: got %b expected %b", i, obs, exp);
      end
    end
    checks++;
    if (size !== 10'd11) begin
      errors++;
      $display("FAIL untracked_size: got %0d expected 11", size);
    end
  endtask

  task automatic test_stuff_error();
    logic [4:0] exp;
    fstart();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, 1'b0);
      exp = (i == 5) ? 5'b01011 : 5'b11000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stuff_err step %0d: got %b expected %b", i, obs, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== 5'b01001) begin
        errors++;
        $display("FAIL error_hold step %0d: got %b expected 01001", i, obs);
      end
    end
    checks++;
    if (size !== 10'd5) begin
      errors++;
      $display("FAIL error_size: got %0d expected 5", size);
    end
  endtask

  task automatic test_error_restart();
    send(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 5'b10000 || size !== 10'd1) begin
      errors++;
      $display("FAIL restart: got %b/%0d expected 10000/1", obs, size);
    end
    sp       = 1'b1;
    rx_bit   = 1'b0;
    stuff_en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b01000 || size !== 10'd0) begin
      errors++;
      $display("FAIL midframe_reset: got %b/%0d expected 01000/0", obs, size);
    end
    sp = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_size_sat();
    fstart();
    for (int i = 0; i < 1030; i++) begin
      send(i[0], 1'b0, 1'b0);
      if (i == 1021) begin
        checks++;
        if (size !== 10'd1022) begin
          errors++;
          $display("FAIL size_pre_sat: got %0d expected 1022", size);
        end
      end
    end
    checks++;
    if (size !== 10'd1023) begin
      errors++;
      $display("FAIL size_sat: got %0d expected 1023", size);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    sp          = 1'b0;
    rx_bit      = 1'b1;
    stuff_en    = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_alternate();
    test_stuff();
    test_chain();
    test_stuff_en_drop();
    test_stuff_error();
    test_error_restart();
    test_size_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
